// File: rtl/mdio_phy_responder_if.sv
// MDIO management bus plus register-file port between
// the MDIO controller side and the PHY responder.
interface mdio_phy_responder_if;
    logic        mdc;
    logic        mdio_oe;
    logic        mdio_out;
    logic        mdio_in;
    logic [4:0]  addr;
    logic [15:0] wr_data;
    logic        memory_wr;
    logic [15:0] rd_data;

    modport master (
        output mdc,
        output mdio_oe,
        output mdio_out,
        output rd_data,
        input  mdio_in,
        input  addr,
        input  wr_data,
        input  memory_wr
    );

    modport slave (
        input  mdc,
        input  mdio_oe,
        input  mdio_out,
        input  rd_data,
        output mdio_in,
        output addr,
        output wr_data,
        output memory_wr
    );
endinterface

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause 22 MDIO peripheral.
// Decodes frames into register writes and serial reads.
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input logic                 clk,
    input logic                 reset,
    mdio_phy_responder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        WRITE,
        READ,
        SKIP
    } state_t;

    state_t      state, state_n;
    logic [5:0]  count, count_n;
    logic [5:0]  cnt_inc;
    logic        mdc_q;
    logic        rise, fall;
    logic [11:0] hdr_sr, hdr_sr_n;
    logic [12:0] hdr;
    logic        phy_hit;
    logic [4:0]  regad, regad_n;
    logic [15:0] wd_sr, wd_sr_n;
    logic [15:0] tx_sr, tx_sr_n;
    logic        mdio_in, mdio_in_n;
    logic [4:0]  addr, addr_n;
    logic [15:0] wr_data, wr_data_n;
    logic        memory_wr, memory_wr_n;

    assign rise = ~mdc_q & bus.mdc;
    assign fall = mdc_q & ~bus.mdc;

    assign cnt_inc = (count == 6'd32) ? count
                                      : count + 6'd1;

    // hdr[12] is ST bit 2, then OP, PHYAD, REGAD
    assign hdr     = {hdr_sr, bus.mdio_out};
    assign phy_hit = hdr[12] &&
                     (hdr[9:5] == PHY_ADDR);

    assign bus.mdio_in   = mdio_in;
    assign bus.addr      = addr;
    assign bus.wr_data   = wr_data;
    assign bus.memory_wr = memory_wr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= 6'd0;
            mdc_q     <= 1'b0;
            hdr_sr    <= 12'd0;
            regad     <= 5'd0;
            wd_sr     <= 16'd0;
            tx_sr     <= 16'd0;
            mdio_in   <= 1'b0;
            addr      <= 5'd0;
            wr_data   <= 16'd0;
            memory_wr <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            mdc_q     <= bus.mdc;
            hdr_sr    <= hdr_sr_n;
            regad     <= regad_n;
            wd_sr     <= wd_sr_n;
            tx_sr     <= tx_sr_n;
            mdio_in   <= mdio_in_n;
            addr      <= addr_n;
            wr_data   <= wr_data_n;
            memory_wr <= memory_wr_n;
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        hdr_sr_n    = hdr_sr;
        regad_n     = regad;
        wd_sr_n     = wd_sr;
        tx_sr_n     = tx_sr;
        mdio_in_n   = mdio_in;
        addr_n      = addr;
        wr_data_n   = wr_data;
        memory_wr_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (rise && bus.mdio_oe &&
                    !bus.mdio_out) begin
                    state_n  = HEADER;
                    count_n  = 6'd1;
                    hdr_sr_n = 12'd0;
                end
            end

            HEADER: begin
                if (rise) begin
                    if (!bus.mdio_oe) begin
                        state_n = IDLE;
                        count_n = 6'd0;
                    end else begin
                        count_n  = cnt_inc;
                        hdr_sr_n = hdr[11:0];
                        if (count == 6'd1 &&
                            !bus.mdio_out) begin
                            state_n = IDLE;
                            count_n = 6'd0;
                        end else if (count == 6'd13) begin
                            regad_n = hdr[4:0];
                            if (phy_hit &&
                                hdr[11:10] == 2'b01) begin
                                state_n = WRITE;
                            end else if (phy_hit &&
                                hdr[11:10] == 2'b10) begin
                                state_n = READ;
                                addr_n  = hdr[4:0];
                            end else begin
                                state_n = SKIP;
                            end
                        end
                    end
                end
            end

            WRITE: begin
                if (rise) begin
                    if (!bus.mdio_oe) begin
                        state_n = IDLE;
                        count_n = 6'd0;
                    end else begin
                        count_n = cnt_inc;
                        wd_sr_n = {wd_sr[14:0],
                                   bus.mdio_out};
                        if (count == 6'd31) begin
                            state_n     = IDLE;
                            count_n     = 6'd0;
                            addr_n      = regad;
                            wr_data_n   = wd_sr_n;
                            memory_wr_n = 1'b1;
                        end
                    end
                end
            end

            READ: begin
                unique case (1'b1)
                    rise: begin
                        count_n = cnt_inc;
                        if (count == 6'd14)
                            tx_sr_n = bus.rd_data;
                    end
                    fall: begin
                        if (count == 6'd15) begin
                            mdio_in_n = 1'b0;
                        end else if (count >= 6'd16 &&
                                     count <= 6'd31) begin
                            mdio_in_n = tx_sr[15];
                            tx_sr_n   = {tx_sr[14:0], 1'b0};
                        end else if (count == 6'd32) begin
                            mdio_in_n = 1'b0;
                            state_n   = IDLE;
                            count_n   = 6'd0;
                        end
                    end
                    default: ;
                endcase
            end

            // foreign frame: ride it out so its data is not a new ST
            SKIP: begin
                if (rise) begin
                    count_n = cnt_inc;
                    if (count == 6'd31) begin
                        state_n = IDLE;
                        count_n = 6'd0;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                count_n = 6'd0;
            end
        endcase
    end

endmodule

// File: doc/mdio_phy_responder.md
# mdio_phy_responder

PHY-side (peripheral) end of the MDIO management link: receives IEEE 802.3 Clause 22 frames driven by the MDIO controller on MDC/MDIO_OUT/MDIO_OE and decodes them. Writes go to a register-file port. Reads return register data serially on MDIO_IN. It is the counterpart of the controller in the MDIO testbench. MDC is treated as a data signal sampled on the system clock, with edges detected internally.

## Interface
- PHY_ADDR, 5'd0: this PHY's address; frames with another PHYAD are ignored.
- clk  in  1  system clock; all logic on posedge clk; MDC at most clk/4.
- reset  in  1  synchronous, active-low reset.
- MDC  in  1  management clock from the controller.
- MDIO_OE  in  1  controller drives MDIO_OUT when 1.
- MDIO_OUT  in  1  serial data from the controller.
- MDIO_IN  out  1  serial data to the controller during read data phase.
- ADDR  out  5  register address (REGAD) of the current or last frame.
- WR_DATA  out  16  write data of the last accepted write.
- MEMORY_WR  out  1  one-clk write strobe; ADDR/WR_DATA valid while high.
- RD_DATA  in  16  register contents at ADDR; must be valid 2 clk after ADDR changes.

## Operation
- Edge detect: register MDC. A rise is a clk cycle with MDC_q=0 and MDC=1. A fall is MDC_q=1 and MDC=0. All sampling and driving happen in that detected cycle.
- Frame bits are numbered 1..32 by MDC rises: ST 1-2 (01), OP 3-4 (01 write, 10 read), PHYAD 5-9, REGAD 10-14, TA 15-16, DATA 17-32. All fields are MSB first.
- States: IDLE, HEADER, WRITE, READ, SKIP.
- IDLE:
  - A rise with MDIO_OE=1 and MDIO_OUT=1 is preamble and is ignored.
  - A rise with MDIO_OE=1 and MDIO_OUT=0 is bit 1: set count=1 and go to HEADER.
- HEADER:
  - Shift MDIO_OUT on each rise.
  - Bit 2 = 0 (bad ST): go to IDLE.
  - MDIO_OE=0 at any rise: abort to IDLE.
  - At rise 14, decode:
    - OP=01 and PHYAD match: go to WRITE.
    - OP=10 and PHYAD match: load ADDR<=REGAD next clk and go to READ.
    - Anything else: go to SKIP.
- WRITE:
  - Shift bits 15-32; TA is not checked.
  - MDIO_OE=0 at any rise: abort to IDLE with no strobe.
  - After rise 32: ADDR<=REGAD, WR_DATA<=data, MEMORY_WR=1 for exactly one clk, then IDLE.
- READ (MDIO_OE is ignored):
  - At rise 15: latch RD_DATA into the TX shift register.
  - Fall after rise 15: MDIO_IN<=0 (TA bit 2).
  - Falls after rises 16..31: MDIO_IN<=data[15]..data[0].
  - Fall after rise 32: MDIO_IN<=0, then IDLE.
- SKIP: count rises to 32, then go to IDLE, even if MDIO_OE drops. This stops a foreign frame's data from being taken as a new start.
- The bit counter is 6 bits and saturates at 32; it does not wrap.

## Timing
- Reset values: MDIO_IN=0, ADDR=0, WR_DATA=0, MEMORY_WR=0, state IDLE, count 0, MDC_q=0.
- Reset is honoured on any clk, including mid-frame. The next frame needs a fresh ST after reset.
- Latency, falls: MDIO_IN updates on the clk edge following the clk cycle in which the MDC fall is detected. That is 1 clk after the fall is seen, 2 clk after MDC drops.
- Latency, rise 14: ADDR updates on the clk edge following the clk cycle in which rise 14 is detected, about 2 clk after MDC rises.
- RD_DATA is sampled at rise 15, at least one MDC period after ADDR updates.
- Latency, rise 32: MEMORY_WR asserts on the clk edge following the clk cycle in which rise 32 is detected, for 1 clk. ADDR and WR_DATA update on the same edge and hold until the next accepted frame.
- MEMORY_WR is never asserted for reads, aborted, skipped or mismatched frames.
- Back-to-back frames: a new ST may start on the rise after rise 32.

## Test plan
- Write: PHY_ADDR=1, 32 preamble ones, then frame 01 01 00001 01010 10 0xBEEF -> one MEMORY_WR pulse with ADDR=0x0A, WR_DATA=0xBEEF; MDIO_IN stays 0.
- Read: RD_DATA=0x1234, frame 01 10 00001 00011, controller releases OE -> ADDR=0x03 after rise 14; bits sampled at rises 16-32 are 0 then 0x1234 MSB first; no MEMORY_WR.
- PHYAD mismatch: write frame with PHYAD=2 and data 0x0000 -> no MEMORY_WR; an immediately following valid write to reg 0x05 with data 0x00FF is accepted.
- Bad ST (00) followed by a valid write -> first frame dropped at rise 2; second write strobes correctly.
- Abort: MDIO_OE=0 after rise 20 of a write -> no MEMORY_WR, state IDLE; the next frame works.
- Reset at rise 24 of a read -> all outputs 0 on the next clk; a following write frame is decoded correctly.
